// File: rtl/sparse_block_pruner.sv
// sparse_block_pruner: keeps the largest-L1 blocks of each row of a dense matrix and zeroes the rest.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_x_data        N*M signed elements, row-wise; i_x_valid / o_x_ready input handshake
//   o_out_data      pruned matrix, row-wise; o_out_keep bit r*BLOCK_NUM+b set when block b of row r is kept
//   o_out_valid     output valid, i_out_ready output ready
module sparse_block_pruner #(
    parameter int N                = 2,
    parameter int M                = 4,
    parameter int X_WIDTH          = 8,
    parameter int BLOCK_NUM        = 2,
    parameter int SPARSE_BLOCK_NUM = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [X_WIDTH-1:0]        i_x_data [N*M],
    input  logic                      i_x_valid,
    output logic                      o_x_ready,
    output logic [X_WIDTH-1:0]        o_out_data [N*M],
    output logic [N*BLOCK_NUM-1:0]    o_out_keep,
    output logic                      o_out_valid,
    input  logic                      i_out_ready
);
    localparam int BS = M / BLOCK_NUM;
    localparam int NS = BLOCK_NUM - SPARSE_BLOCK_NUM;
    localparam int NW = X_WIDTH + $clog2(BS);
    localparam int CW = $clog2(BLOCK_NUM) + 1;
    localparam int SW = $clog2(N * BLOCK_NUM + 1);

    if (SPARSE_BLOCK_NUM < 0 || SPARSE_BLOCK_NUM >= BLOCK_NUM || M % BLOCK_NUM != 0) begin : g_bad_params
        $fatal(1, "sparse_block_pruner: illegal BLOCK_NUM/SPARSE_BLOCK_NUM/M combination");
    end

    typedef enum logic [1:0] {IDLE, NORM, SELECT, OUT} state_t;

    state_t                   r_state, w_next;
    logic [X_WIDTH-1:0]       r_buf      [N*M];
    logic [X_WIDTH-1:0]       r_out_data [N*M];
    logic [X_WIDTH-1:0]       w_masked   [N*M];
    logic [NW-1:0]            r_norm     [N*BLOCK_NUM];
    logic [NW-1:0]            w_norm     [N*BLOCK_NUM];
    logic [N*BLOCK_NUM-1:0]   r_keep, r_out_keep, w_pick, w_keep_next;
    logic [CW-1:0]            r_cnt;
    logic                     w_last, w_found;
    logic [NW-1:0]            w_best;
    logic [SW-1:0]            w_sel;

    // Unsigned magnitude: the most negative value maps to 2^(X_WIDTH-1) without overflow.
    function automatic logic [X_WIDTH-1:0] abs_u(input logic [X_WIDTH-1:0] v);
        return v[X_WIDTH-1] ? -v : v;
    endfunction

    // Flat block index r*BLOCK_NUM+b starts at element (r*BLOCK_NUM+b)*BS because M = BLOCK_NUM*BS.
    always_comb begin
        for (int i = 0; i < N*BLOCK_NUM; i++) begin
            w_norm[i] = '0;
            for (int k = 0; k < BS; k++)
                w_norm[i] = w_norm[i] + NW'(abs_u(r_buf[i*BS+k]));
        end
    end

    // Per row, pick the largest unkept block; strict > keeps the lowest index on ties.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        w_best  = '0;
        w_sel   = '0;
        for (int r = 0; r < N; r++) begin
            w_found = 1'b0;
            w_best  = '0;
            w_sel   = '0;
            for (int b = 0; b < BLOCK_NUM; b++)
                if (!r_keep[r*BLOCK_NUM+b] && (!w_found || r_norm[r*BLOCK_NUM+b] > w_best)) begin
                    w_found = 1'b1;
                    w_best  = r_norm[r*BLOCK_NUM+b];
                    w_sel   = SW'(r*BLOCK_NUM+b);
                end
            if (w_found)
                w_pick[w_sel] = 1'b1;
        end
    end

    assign w_keep_next = r_keep | w_pick;
    assign w_last      = r_cnt == CW'(NS-1);

    always_comb begin
        for (int j = 0; j < N*M; j++)
            w_masked[j] = w_keep_next[j/BS] ? r_buf[j] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:   w_next = i_x_valid ? NORM : IDLE;
            NORM:   w_next = SELECT;
            SELECT: w_next = w_last ? OUT : SELECT;
            OUT:    w_next = i_out_ready ? IDLE : OUT;
        endcase
    end

    always_comb begin
        o_x_ready   = r_state == IDLE;
        o_out_valid = r_state == OUT;
        o_out_data  = r_out_data;
        o_out_keep  = r_out_keep;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf      <= '{default: '0};
            r_norm     <= '{default: '0};
            r_out_data <= '{default: '0};
            r_out_keep <= '0;
            r_keep     <= '0;
            r_cnt      <= '0;
        end else begin
            if (r_state == IDLE && i_x_valid)
                r_buf <= i_x_data;
            if (r_state == NORM) begin
                r_norm <= w_norm;
                r_keep <= '0;
                r_cnt  <= '0;
            end
            if (r_state == SELECT) begin
                r_keep <= w_keep_next;
                r_cnt  <= r_cnt + 1'b1;
            end
            if (r_state == SELECT && w_last) begin
                r_out_data <= w_masked;
                r_out_keep <= w_keep_next;
            end
        end
    end
endmodule

// File: tb/tb_sparse_block_pruner.sv
// tb_sparse_block_pruner: table, hand-written and random checks of three pruner configurations.
module tb_sparse_block_pruner;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] xa [8];
    logic [7:0] xb [16];
    logic [7:0] o0 [8];
    logic [7:0] o2 [8];
    logic [7:0] o1 [16];
    logic [3:0] k0, k2;
    logic [7:0] k1;
    logic [2:0] v = '0, orr = '0, xr, ov;

    int checks = 0, failures = 0;
    int xs [16], es [16], gd [16], snap [16];
    int ek, gk, glat;

    typedef struct {
        int x  [8];
        int ed [8];
        int ek;
    } vec_t;
    vec_t vt [4];

    always #5 clk = ~clk;

    sparse_block_pruner u0 (.clk(clk), .rst(rst), .i_x_data(xa), .i_x_valid(v[0]), .o_x_ready(xr[0]),
        .o_out_data(o0), .o_out_keep(k0), .o_out_valid(ov[0]), .i_out_ready(orr[0]));
    sparse_block_pruner #(.N(2), .M(8), .BLOCK_NUM(4), .SPARSE_BLOCK_NUM(1)) u1 (.clk(clk), .rst(rst),
        .i_x_data(xb), .i_x_valid(v[1]), .o_x_ready(xr[1]), .o_out_data(o1), .o_out_keep(k1),
        .o_out_valid(ov[1]), .i_out_ready(orr[1]));
    sparse_block_pruner #(.SPARSE_BLOCK_NUM(0)) u2 (.clk(clk), .rst(rst), .i_x_data(xa), .i_x_valid(v[2]),
        .o_x_ready(xr[2]), .o_out_data(o2), .o_out_keep(k2), .o_out_valid(ov[2]), .i_out_ready(orr[2]));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int cfg_m(input int d);
        return d == 1 ? 8 : 4;
    endfunction

    function automatic int cfg_bn(input int d);
        return d == 1 ? 4 : 2;
    endfunction

    function automatic int cfg_sp(input int d);
        return d == 2 ? 0 : 1;
    endfunction

    // Block b is kept when fewer than NONSPARSE blocks of its row outrank it
    // (larger L1 norm, or equal norm at a lower index).
    task automatic model(input int d);
        int m, bn, bs, ns, rank, a, idx;
        int nrm [8];
        m  = cfg_m(d);
        bn = cfg_bn(d);
        bs = m / bn;
        ns = bn - cfg_sp(d);
        for (int r = 0; r < 2; r++)
            for (int b = 0; b < bn; b++) begin
                nrm[r*bn+b] = 0;
                for (int k = 0; k < bs; k++) begin
                    a = xs[r*m+b*bs+k];
                    nrm[r*bn+b] += a < 0 ? -a : a;
                end
            end
        ek = 0;
        for (int r = 0; r < 2; r++)
            for (int b = 0; b < bn; b++) begin
                rank = 0;
                for (int c = 0; c < bn; c++)
                    if (nrm[r*bn+c] > nrm[r*bn+b] || (nrm[r*bn+c] == nrm[r*bn+b] && c < b))
                        rank++;
                if (rank < ns)
                    ek |= 1 << (r*bn+b);
                for (int k = 0; k < bs; k++) begin
                    idx = r*m+b*bs+k;
                    es[idx] = rank < ns ? xs[idx] : 0;
                end
            end
    endtask

    task automatic drive_x(input int d);
        for (int i = 0; i < 2*cfg_m(d); i++)
            if (d == 1)
                xb[i] = 8'(xs[i]);
            else
                xa[i] = 8'(xs[i]);
    endtask

    task automatic scramble();
        for (int i = 0; i < 16; i++)
            xb[i] = 8'($urandom);
        for (int i = 0; i < 8; i++)
            xa[i] = 8'($urandom);
    endtask

    task automatic randomize_xs();
        for (int i = 0; i < 16; i++)
            xs[i] = ($urandom_range(0, 7) == 0) ? -128 : int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic capture(input int d);
        gk = d == 0 ? int'(k0) : d == 1 ? int'(k1) : int'(k2);
        for (int i = 0; i < 2*cfg_m(d); i++)
            if (d == 0)
                gd[i] = int'($signed(o0[i]));
            else if (d == 1)
                gd[i] = int'($signed(o1[i]));
            else
                gd[i] = int'($signed(o2[i]));
    endtask

    task automatic cmp_data(input string nm, input int n, input int ref_v [16]);
        int bad, first;
        bad   = 0;
        first = -1;
        for (int i = 0; i < n; i++)
            if (gd[i] != ref_v[i]) begin
                bad++;
                if (first < 0)
                    first = i;
            end
        if (first >= 0)
            $display("  %s element %0d got %0d expected %0d", nm, first, gd[first], ref_v[first]);
        chk({nm, " wrong_elements"}, bad, 0);
    endtask

    task automatic wait_out(input int d);
        while (!ov[d] && glat < 40) begin
            @(posedge clk);
            #1;
            glat++;
        end
    endtask

    task automatic run(input int d, input string nm);
        int ns;
        ns = cfg_bn(d) - cfg_sp(d);
        model(d);
        @(negedge clk);
        drive_x(d);
        v[d] = 1'b1;
        chk({nm, " x_ready"}, int'(xr[d]), 1);
        @(posedge clk);
        #1;
        v[d] = 1'b0;
        scramble();
        glat = 1;
        wait_out(d);
        chk({nm, " latency"}, glat, ns + 2);
        capture(d);
        cmp_data({nm, " data"}, 2*cfg_m(d), es);
        chk({nm, " keep"}, gk, ek);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(negedge clk);
        orr[d] = 1'b1;
        @(posedge clk);
        #1;
        orr[d] = 1'b0;
        chk({nm, " valid_drop"}, int'(ov[d]), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0].x = '{1, 2, -10, 3, 5, -5, 0, 1};
        vt[0].ed = '{0, 0, -10, 3, 5, -5, 0, 0};
        vt[0].ek = 'b0110;
        vt[1].x = '{2, 2, -1, -3, 0, 0, 0, 0};
        vt[1].ed = '{2, 2, 0, 0, 0, 0, 0, 0};
        vt[1].ek = 'b0101;
        vt[2].x = '{-128, 0, 127, 0, -1, -1, 1, 1};
        vt[2].ed = '{-128, 0, 0, 0, -1, -1, 0, 0};
        vt[2].ek = 'b0101;
        vt[3].x = '{127, 127, -128, -128, 0, 1, -128, -128};
        vt[3].ed = '{0, 0, -128, -128, 0, 0, -128, -128};
        vt[3].ek = 'b1010;
        for (int i = 0; i < 16; i++) begin
            xb[i] = '0;
            if (i < 8)
                xa[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset x_ready", int'(xr), 7);
        chk("reset out_valid", int'(ov), 0);
        chk("reset keep u0", int'(k0), 0);
        chk("reset keep u1", int'(k1), 0);
        capture(0);
        for (int i = 0; i < 16; i++)
            snap[i] = 0;
        cmp_data("reset data u0", 8, snap);
        rst = 1'b0;
        #1;
        chk("idle x_ready", int'(xr), 7);

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 16; i++)
                xs[i] = i < 8 ? vt[t].x[i] : 0;
            run(0, $sformatf("vec%0d", t));
            for (int i = 0; i < 16; i++)
                snap[i] = i < 8 ? vt[t].ed[i] : 0;
            cmp_data($sformatf("vec%0d table_data", t), 8, snap);
            chk($sformatf("vec%0d table_keep", t), gk, vt[t].ek);
        end

        // Backpressure: output held for five cycles while a new matrix is offered.
        for (int i = 0; i < 16; i++)
            xs[i] = i < 8 ? vt[0].x[i] : 0;
        @(negedge clk);
        drive_x(0);
        v[0] = 1'b1;
        @(posedge clk);
        #1;
        v[0] = 1'b0;
        glat = 1;
        wait_out(0);
        chk("bp latency", glat, 3);
        capture(0);
        snap = gd;
        @(negedge clk);
        for (int i = 0; i < 8; i++)
            xa[i] = 8'(7 + i);
        v[0] = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp out_valid", int'(ov[0]), 1);
            chk("bp x_ready", int'(xr[0]), 0);
            chk("bp keep", int'(k0), 'b0110);
            capture(0);
            cmp_data("bp data", 8, snap);
        end
        @(negedge clk);
        orr[0] = 1'b1;
        v[0] = 1'b0;
        @(posedge clk);
        #1;
        orr[0] = 1'b0;
        chk("bp release out_valid", int'(ov[0]), 0);
        chk("bp release x_ready", int'(xr[0]), 1);
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("bp no accept", int'(ov[0]), 0);
        end

        // Reset during the second SELECT cycle of the four-block instance.
        randomize_xs();
        @(negedge clk);
        drive_x(1);
        v[1] = 1'b1;
        @(posedge clk);
        #1;
        v[1] = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_sel out_valid", int'(ov[1]), 0);
        chk("rst_sel x_ready", int'(xr[1]), 1);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("rst_sel stays idle", int'(ov[1]), 0);
        end
        randomize_xs();
        run(1, "after_rst");

        // Nothing pruned: data must pass through unchanged.
        randomize_xs();
        run(2, "sp0");
        chk("sp0 keep all", gk, 'hF);
        cmp_data("sp0 passthrough", 8, xs);

        for (int t = 0; t < 20; t++) begin
            randomize_xs();
            run(0, $sformatf("rnd0_%0d", t));
        end
        for (int t = 0; t < 10; t++) begin
            randomize_xs();
            run(1, $sformatf("rnd1_%0d", t));
        end
        for (int t = 0; t < 10; t++) begin
            randomize_xs();
            run(2, $sformatf("rnd2_%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sparse_block_pruner.md
Name: sparse_block_pruner

Overview:
- Upstream stage of the block-sparse matmul. Takes a dense N x M X matrix, row-wise ordering.
- Per row, splits M into BLOCK_NUM contiguous blocks of BLOCK_SIZE = M/BLOCK_NUM elements.
- Keeps the NONSPARSE_BLOCK_NUM = BLOCK_NUM - SPARSE_BLOCK_NUM blocks with the largest L1 magnitude and zeroes the rest.
- Guarantees the downstream zero-block detector and mux see the block count they are sized for. Multi-cycle, FSM-driven, with valid/ready on both sides.

Parameters:
- N, 2, rows of X
- M, 4, columns of X; must be divisible by BLOCK_NUM
- X_WIDTH, 8, signed two's-complement element width
- BLOCK_NUM, 2, blocks per row
- SPARSE_BLOCK_NUM, 1, blocks forced to zero per row; 0 <= SPARSE_BLOCK_NUM < BLOCK_NUM, fatal elaboration assertion otherwise

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- x_data  in  [X_WIDTH-1:0] x [N*M]  dense input matrix, row-wise
- x_valid  in  1  input valid
- x_ready  out  1  input ready
- out_data  out  [X_WIDTH-1:0] x [N*M]  pruned matrix, row-wise
- out_keep  out  N*BLOCK_NUM  bit i*BLOCK_NUM+b = 1 if block b of row i kept
- out_valid  out  1  output valid
- out_ready  in  1  output ready

Behaviour:
- Single clock domain. Reset is synchronous and active-high; all state updates occur on the rising edge of clk.
- FSM states: IDLE, NORM, SELECT, OUT.
- Reset values: state=IDLE, x_ready=1, out_valid=0, out_data all 0, out_keep all 0, select counter 0. Reset wins over any handshake in the same cycle.
- IDLE:
  - x_ready=1, combinational from state only.
  - On x_valid&&x_ready, register x_data into the input buffer and go to NORM.
- NORM (1 cycle):
  - Per row and block, norm = sum of |x| over the block. |x| is computed as an unsigned X_WIDTH-bit value; |-2^(X_WIDTH-1)| = 2^(X_WIDTH-1) exactly.
  - Norm width is X_WIDTH+$clog2(BLOCK_SIZE), with no saturation.
  - Register the norms, clear keep mask and counter, go to SELECT.
- SELECT (exactly NONSPARSE_BLOCK_NUM cycles):
  - Each cycle, every row independently sets the keep bit of the largest-norm block not yet kept. Ties go to the lowest block index.
  - Counter increments each cycle. When counter == NONSPARSE_BLOCK_NUM-1, go to OUT.
  - All-zero blocks can be kept; the count of kept blocks is always exact.
- OUT:
  - out_valid=1; out_data = buffer with unkept blocks forced to 0; out_keep = mask. Both are registered and stable while out_valid=1.
  - On out_ready=1, deassert out_valid and go to IDLE.
- x_ready=0 in NORM, SELECT and OUT. There is no overlap between matrices.
- Latency: out_valid rises NONSPARSE_BLOCK_NUM+2 cycles after the input handshake edge.
- Minimum initiation interval: NONSPARSE_BLOCK_NUM+3 cycles.
- If SPARSE_BLOCK_NUM=0, all blocks are kept after BLOCK_NUM select cycles and data passes through unchanged.
- Reset mid-operation (any state) returns to IDLE, discards buffered data and drops out_valid the next cycle.
- x_data changing after the handshake has no effect on the result.

Test Plan:
(Defaults N=2, M=4, BLOCK_NUM=2, SPARSE=1, X_WIDTH=8.)
- Basic prune and latency:
  - Stimulus: row0=[1,2,-10,3], row1=[5,-5,0,1].
  - Required: norms 3/13 and 10/1, so out_data=[0,0,-10,3, 5,-5,0,0] and out_keep=4'b0110 (row1 block0, row0 block1).
  - Required: out_valid exactly 3 cycles after the handshake.
- Tie-break:
  - Stimulus: row0=[2,2,-1,-3], norms 4/4.
  - Required: keep block0 -> [2,2,0,0].
- Most-negative magnitude:
  - Stimulus: row0=[-128,0,127,0].
  - Required: norms 128/127, keep block0 -> [-128,0,0,0].
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in OUT, and present x_valid=1 with new data.
  - Required: out_data/out_keep stable, x_ready=0, new data not accepted.
  - Required: after out_ready=1 for one cycle, IDLE with x_ready=1 next cycle.
- Reset mid-SELECT:
  - Setup: BLOCK_NUM=4, SPARSE=1 (3 select cycles).
  - Stimulus: assert rst in the 2nd SELECT cycle.
  - Required: next cycle state=IDLE, out_valid=0, x_ready=1.
  - Required: the following matrix is processed correctly, with no stale mask bits.
- SPARSE_BLOCK_NUM=0:
  - Stimulus: arbitrary input.
  - Required: out_data == x_data, out_keep all 1s, latency BLOCK_NUM+2.
